// File: rtl/t09_snake_pkg.sv
// Shared snake-game types: game state encoding, one-hot directions and the
// reset direction of the direction FSM.
package t09_snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_UP    = 4'b0001;
    localparam dir_t DIR_DOWN  = 4'b0010;
    localparam dir_t DIR_LEFT  = 4'b0100;
    localparam dir_t DIR_RIGHT = 4'b1000;

    localparam dir_t DIR_FSM_RESET = DIR_RIGHT;

endpackage

// File: rtl/t09_dir_queue.sv
// Two-entry direction press FIFO: accepts only one-hot values, drops a press
// equal to the current tail, and lets a same-cycle pop make room for a push.
module t09_dir_queue
    import t09_snake_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  dir_t din,
    input  logic pop,
    input  logic flush,
    output dir_t dout,
    output logic empty,
    output logic full
);

    dir_t       r_mem0;
    dir_t       r_mem1;
    logic [1:0] r_count;

    logic w_onehot;
    dir_t w_tail;
    logic w_dup;
    logic w_pop;
    logic w_push;

    assign w_onehot = (din != 4'b0000) && ((din & (din - 4'd1)) == 4'b0000);
    assign w_tail   = (r_count == 2'd2) ? r_mem1 : r_mem0;
    assign w_dup    = (r_count != 2'd0) && (din == w_tail);
    assign w_pop    = pop && (r_count != 2'd0);
    // A full queue still takes a push when the head leaves in the same cycle
    assign w_push   = push && w_onehot && !w_dup && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_mem0 <= din;
                    else                 r_mem1 <= din;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_mem0 <= din;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = r_mem0;
    assign empty = (r_count == 2'd0);
    assign full  = (r_count == 2'd2);

endmodule

// File: rtl/t09_move_scheduler.sv
// Snake move scheduler: game state machine, movement tick with speed-up, and
// queued direction requests. Optional turbo input under T09_MOVE_SCHED_TURBO_EN.
module t09_move_scheduler
    import t09_snake_pkg::*;
#(
    parameter int              CNT_W       = 24,
    parameter logic [CNT_W-1:0] BASE_PERIOD = 24'd5_000_000,
    parameter logic [CNT_W-1:0] STEP        = 24'd250_000,
    parameter logic [CNT_W-1:0] MIN_PERIOD  = 24'd1_000_000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause_btn,
    input  logic       game_over,
    input  logic       apple_eaten,
    input  logic [3:0] btn_dir,
`ifdef T09_MOVE_SCHED_TURBO_EN
    input  logic       turbo,
`endif
    output logic [3:0] direction_a,
    output logic       pulse,
    output logic       sync,
    output logic [1:0] state,
    output logic [3:0] level
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [3:0]       r_level;
    logic             r_sync;

    logic [CNT_W-1:0] w_eff;
    logic             w_run;
    logic             w_pulse;
    logic             w_pre;
    logic             w_pop;
    logic             w_push;
    logic             w_flush;
    logic             w_start_ok;
    logic             w_q_empty;
    logic             w_q_full;
    dir_t             w_q_dout;
    logic [CNT_W:0]   w_sat_limit;

`ifdef T09_MOVE_SCHED_TURBO_EN
    logic [CNT_W-1:0] w_half;
    assign w_half = r_period >> 1;
    assign w_eff  = (turbo && (r_state == ST_RUN))
                  ? ((w_half < CNT_W'(2)) ? CNT_W'(2) : w_half)
                  : r_period;
`else
    assign w_eff = r_period;
`endif

    assign w_run      = (r_state == ST_RUN) && !rst && !game_over;
    // >= rather than == so a shrinking period never lets cnt run past the tick
    assign w_pulse    = w_run && (r_cnt >= (w_eff - CNT_W'(1)));
    assign w_pre      = w_run && (r_cnt == (w_eff - CNT_W'(2)));
    assign w_pop      = w_pre && !w_q_empty;
    assign w_push     = (r_state == ST_RUN) && !game_over && !pause_btn;
    assign w_flush    = game_over && ((r_state == ST_RUN) || (r_state == ST_PAUSE));
    assign w_start_ok = start && !game_over && !pause_btn &&
                        ((r_state == ST_IDLE) || (r_state == ST_OVER));
    assign w_sat_limit = {1'b0, MIN_PERIOD} + {1'b0, STEP};

    t09_dir_queue u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (btn_dir),
        .pop   (w_pop),
        .flush (w_flush),
        .dout  (w_q_dout),
        .empty (w_q_empty),
        .full  (w_q_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= BASE_PERIOD;
            r_level  <= 4'd0;
            r_sync   <= 1'b0;
        end else begin
            r_sync <= w_start_ok;
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (r_state == ST_IDLE || w_start_ok) begin
                        r_cnt    <= '0;
                        r_period <= BASE_PERIOD;
                        r_level  <= 4'd0;
                    end
                    if (w_start_ok) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (game_over) begin
                        r_state <= ST_OVER;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_pulse ? '0 : r_cnt + CNT_W'(1);
                        if (pause_btn) begin
                            r_state <= ST_PAUSE;
                        end else if (apple_eaten) begin
                            r_period <= ({1'b0, r_period} >= w_sat_limit)
                                      ? (r_period - STEP) : MIN_PERIOD;
                            if (r_level != 4'd15) r_level <= r_level + 4'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (game_over) begin
                        r_state <= ST_OVER;
                        r_cnt   <= '0;
                    end else if (pause_btn) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign direction_a = w_pop ? w_q_dout : 4'b0000;
    assign pulse       = w_pulse;
    assign sync        = r_sync && !rst;
    assign state       = r_state;
    assign level       = r_level;

endmodule
